// File: rtl/bc_screen_seq_if.sv
// Button and digit-word bundle between the screen sequencer and its neighbours.
// The slave side is the sequencer: it takes the raw button and drives the
// eight digit words plus the screen index and accepted-press pulse.
interface bc_screen_seq_if;
  logic       confirma;
  logic [6:0] d1;
  logic [6:0] d2;
  logic [6:0] d3;
  logic [6:0] d4;
  logic [6:0] d5;
  logic [6:0] d6;
  logic [6:0] d7;
  logic [6:0] d8;
  logic [2:0] screen;
  logic       step;

  modport master (
    output confirma,
    input  d1, d2, d3, d4, d5, d6, d7, d8,
    input  screen,
    input  step
  );

  modport slave (
    input  confirma,
    output d1, d2, d3, d4, d5, d6, d7, d8,
    output screen,
    output step
  );
endinterface

// File: rtl/bc_screen_seq.sv
// Screen sequencer for the 8-digit display driver.
// Synchronizes and debounces the confirm button, turns each clean press into
// a one-cycle step, and walks a fixed 5-screen message ROM. The last screen
// blinks by gating the enable bit of every digit.
//
// screen | meaning
// -------+------------------------------------------
//   0    | first message (also the reset screen)
//   1    | second message
//   2    | third message
//   3    | fourth message
//   4    | final message, blinking
module bc_screen_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 25_000_000,
  parameter int unsigned NUM_SCREENS     = 5
) (
  input logic          clock,
  input logic          reset,
  bc_screen_seq_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_TC = BL_W'(BLINK_CYCLES - 1);

  localparam logic [2:0] SCR0 = 3'd0;
  localparam logic [2:0] SCR1 = 3'd1;
  localparam logic [2:0] SCR2 = 3'd2;
  localparam logic [2:0] SCR3 = 3'd3;
  localparam logic [2:0] SCR4 = 3'd4;
  localparam logic [2:0] LAST_SCREEN = 3'(NUM_SCREENS - 1);

  // Element [7] is d8 (leftmost), element [0] is d1.
  function automatic logic [7:0][4:0] rom_codes(input logic [2:0] scr);
    logic [7:0][4:0] codes;
    case (scr)
      SCR1:    codes = {5'h05, 5'h02, 5'h10, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A};
      SCR2:    codes = {5'h05, 5'h01, 5'h10, 5'h0F, 5'h09, 5'h07, 5'h06, 5'h06};
      SCR3:    codes = {5'h05, 5'h02, 5'h10, 5'h0F, 5'h09, 5'h07, 5'h06, 5'h06};
      SCR4:    codes = {5'h0B, 5'h09, 5'h0D, 5'h0D, 5'h06, 5'h07, 5'h0E, 5'h07};
      default: codes = {5'h05, 5'h01, 5'h10, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A};
    endcase
    return codes;
  endfunction

  // Digit word is {en, code, dp}; dp=1 keeps the decimal point dark.
  function automatic logic [7:0][6:0] digit_words(input logic [2:0] scr, input logic off);
    logic [7:0][4:0] codes;
    logic [7:0][6:0] words;
    codes = rom_codes(scr);
    for (int i = 0; i < 8; i++) begin
      words[i] = {~off, codes[i], 1'b1};
    end
    return words;
  endfunction

  localparam logic [7:0][6:0] RST_DIGITS = digit_words(SCR0, 1'b0);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            db_q, db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            step_q, step_d;
  logic [2:0]      screen_q, screen_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_off_q, blink_off_d;
  logic [7:0][6:0] digits_q, digits_d;

  // Two-flop synchronizer; only the second stage feeds the debouncer.
  always_comb begin
    sync1_d = bus.confirma;
    sync2_d = sync1_q;
  end

  // Debounce: count consecutive disagreeing samples, adopt the new level at
  // terminal count; any agreeing sample throws the partial count away.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_TC) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    step_d = db_d & ~db_q;
  end

  // Advance the screen one cycle after each accepted press, wrapping at the end.
  always_comb begin
    screen_d = screen_q;
    if (step_q) begin
      screen_d = (screen_q == LAST_SCREEN) ? SCR0 : screen_q + 3'd1;
    end
  end

  // Blink timer runs only while parked on the final screen; any screen change
  // restarts it lit.
  always_comb begin
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if ((screen_d == screen_q) && (screen_q == SCR4)) begin
      if (blink_cnt_q == BL_TC) begin
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
      end
    end
  end

  // Digit words follow the next screen so they change on the same edge.
  always_comb begin
    digits_d = digit_words(screen_d, blink_off_d);
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_q        <= 1'b0;
      db_cnt_q    <= '0;
      step_q      <= 1'b0;
      screen_q    <= SCR0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      digits_q    <= RST_DIGITS;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      step_q      <= step_d;
      screen_q    <= screen_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      digits_q    <= digits_d;
    end
  end

  assign bus.d1     = digits_q[0];
  assign bus.d2     = digits_q[1];
  assign bus.d3     = digits_q[2];
  assign bus.d4     = digits_q[3];
  assign bus.d5     = digits_q[4];
  assign bus.d6     = digits_q[5];
  assign bus.d7     = digits_q[6];
  assign bus.d8     = digits_q[7];
  assign bus.screen = screen_q;
  assign bus.step   = step_q;

endmodule

// File: tb/tb_bc_screen_seq.sv
// Bench for the screen sequencer: directed scenarios plus a randomized button
// stream compared against a behavioural model of press acceptance.
module tb_bc_screen_seq;
  localparam int DEB   = 4;
  localparam int BLINK = 8;
  localparam int LAT   = 2 + DEB + 1;

  logic clock = 1'b0;
  logic reset;
  int   nchecks = 0;
  int   nerrors = 0;

  bc_screen_seq_if bus ();

  bc_screen_seq #(
    .DEBOUNCE_CYCLES (DEB),
    .BLINK_CYCLES    (BLINK),
    .NUM_SCREENS     (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Message ROM, codes listed d8..d1.
  int rom [5][8] = '{
    '{5, 1, 16,  6,  7, 8,  9, 10},
    '{5, 2, 16,  6,  7, 8,  9, 10},
    '{5, 1, 16, 15,  9, 7,  6,  6},
    '{5, 2, 16, 15,  9, 7,  6,  6},
    '{11, 9, 13, 13, 6, 7, 14,  7}
  };

  function automatic logic [55:0] exp_digits(int scr, bit off);
    logic [55:0] v;
    int          c;
    for (int i = 0; i < 8; i++) begin
      c = rom[scr][7-i];
      v[i*7 +: 7] = {~off, c[4:0], 1'b1};
    end
    return v;
  endfunction

  function automatic logic [55:0] dut_digits();
    return {bus.d8, bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1};
  endfunction

  function automatic logic [7:0] dut_en();
    return {bus.d8[6], bus.d7[6], bus.d6[6], bus.d5[6], bus.d4[6], bus.d3[6], bus.d2[6], bus.d1[6]};
  endfunction

  // Reference model: a press is accepted once the button, seen two cycles
  // late, has disagreed with the accepted level for DEB samples in a row.
  // The screen follows each accepted rise a cycle later; on the last screen
  // the display is dark during every odd BLINK-long interval since entry.
  logic [1:0] m_hist = '0;
  int         m_run  = 0;
  logic       m_db   = 1'b0;
  logic       m_step = 1'b0;
  int         m_scr  = 0;
  int         m_on4  = 0;
  bit         m_off;

  assign m_off = (m_scr == 4) && (((m_on4 / BLINK) % 2) == 1);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_hist <= '0;
      m_run  <= 0;
      m_db   <= 1'b0;
      m_step <= 1'b0;
      m_scr  <= 0;
      m_on4  <= 0;
    end else begin
      int   run_n;
      logic db_n;
      db_n  = m_db;
      run_n = (m_hist[1] != m_db) ? m_run + 1 : 0;
      if (run_n == DEB) begin
        db_n  = m_hist[1];
        run_n = 0;
      end
      m_run  <= run_n;
      m_db   <= db_n;
      m_step <= db_n & ~m_db;
      m_hist <= {m_hist[0], bus.confirma};
      if (m_step) begin
        m_scr <= (m_scr + 1) % 5;
        m_on4 <= 0;
      end else if (m_scr == 4) begin
        m_on4 <= m_on4 + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.confirma = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic press(int hold, int rel);
    bus.confirma = 1'b1;
    repeat (hold) tick();
    bus.confirma = 1'b0;
    repeat (rel) tick();
  endtask

  task automatic test_reset();
    logic [6:0] d8_exp;
    logic [6:0] d1_exp;
    d8_exp = {1'b1, 5'h05, 1'b1};
    d1_exp = {1'b1, 5'h0A, 1'b1};
    reset = 1'b0;
    bus.confirma = 1'b0;
    #1;
    tick();
    tick();
    nchecks++;
    if (bus.screen !== 3'd0) begin
      nerrors++;
      $display("FAIL reset_screen: got %0d expected 0", bus.screen);
    end
    nchecks++;
    if (bus.d8 !== d8_exp) begin
      nerrors++;
      $display("FAIL reset_d8: got %h expected %h", bus.d8, d8_exp);
    end
    nchecks++;
    if (bus.d1 !== d1_exp) begin
      nerrors++;
      $display("FAIL reset_d1: got %h expected %h", bus.d1, d1_exp);
    end
    nchecks++;
    if (dut_digits() !== exp_digits(0, 0)) begin
      nerrors++;
      $display("FAIL reset_digits: got %h expected %h", dut_digits(), exp_digits(0, 0));
    end
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      nchecks++;
      if (bus.step !== 1'b0 || bus.screen !== 3'd0) begin
        nerrors++;
        $display("FAIL idle_after_reset: cycle %0d step %b screen %0d expected step 0 screen 0",
                 k, bus.step, bus.screen);
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int nstep = 0;
    bus.confirma = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.step === 1'b1) begin
        nstep++;
        if (first < 0) first = k;
      end
      if (first > 0 && k == first + 1) begin
        nchecks++;
        if (bus.screen !== 3'd1) begin
          nerrors++;
          $display("FAIL press_screen: got %0d expected 1", bus.screen);
        end
        nchecks++;
        if (bus.d7[5:1] !== 5'h02) begin
          nerrors++;
          $display("FAIL press_d7_code: got %h expected 02", bus.d7[5:1]);
        end
      end
    end
    // Latency counts the cycle in which confirma rose as cycle 1.
    nchecks++;
    if (first + 1 != LAT) begin
      nerrors++;
      $display("FAIL press_latency: got %0d expected %0d", first + 1, LAT);
    end
    bus.confirma = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.step === 1'b1) nstep++;
    end
    nchecks++;
    if (nstep != 1) begin
      nerrors++;
      $display("FAIL press_step_count: got %0d expected 1", nstep);
    end
  endtask

  task automatic test_bounce();
    int nstep = 0;
    for (int k = 0; k < 30; k++) begin
      bus.confirma = ((k / 2) % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      if (bus.step === 1'b1) nstep++;
    end
    bus.confirma = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.step === 1'b1) nstep++;
    end
    nchecks++;
    if (nstep != 0) begin
      nerrors++;
      $display("FAIL bounce_steps: got %0d expected 0", nstep);
    end
    nchecks++;
    if (bus.screen !== 3'd1) begin
      nerrors++;
      $display("FAIL bounce_screen: got %0d expected 1", bus.screen);
    end
  endtask

  task automatic test_sequence();
    int exp_seq [5] = '{1, 2, 3, 4, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press($urandom_range(6, 12), $urandom_range(6, 12));
      nchecks++;
      if (bus.screen !== 3'(exp_seq[i])) begin
        nerrors++;
        $display("FAIL seq_screen: press %0d got %0d expected %0d", i + 1, bus.screen, exp_seq[i]);
      end
      if (i == 3) begin
        nchecks++;
        if (bus.d8[5:1] !== 5'h0B || bus.d2[5:1] !== 5'h0E) begin
          nerrors++;
          $display("FAIL seq_screen4_codes: d8 %h d2 %h expected 0b 0e", bus.d8[5:1], bus.d2[5:1]);
        end
      end
      if (i == 4) begin
        nchecks++;
        if (bus.d1[5:1] !== 5'h0A || dut_en() !== 8'hFF) begin
          nerrors++;
          $display("FAIL seq_wrap: d1 code %h en %b expected 0a 11111111", bus.d1[5:1], dut_en());
        end
      end
    end
  endtask

  task automatic test_blink();
    bit          entered = 0;
    bit          left = 0;
    logic [55:0] code_mask;
    logic [7:0]  en_exp;
    code_mask = {8{7'h3F}};
    do_reset();
    repeat (3) press(8, 8);
    bus.confirma = 1'b1;
    for (int k = 0; k < 20 && !entered; k++) begin
      tick();
      if (bus.screen === 3'd4) entered = 1;
    end
    nchecks++;
    if (!entered) begin
      nerrors++;
      $display("FAIL blink_enter: screen %0d expected 4 within 20 cycles", bus.screen);
    end
    bus.confirma = 1'b0;
    for (int n = 0; n < 48; n++) begin
      en_exp = (((n / BLINK) % 2) == 0) ? 8'hFF : 8'h00;
      nchecks++;
      if (dut_en() !== en_exp || (dut_digits() & code_mask) !== (exp_digits(4, 0) & code_mask)) begin
        nerrors++;
        $display("FAIL blink_pattern: n %0d en %b expected %b digits %h", n, dut_en(), en_exp, dut_digits());
      end
      tick();
    end
    bus.confirma = 1'b1;
    for (int k = 0; k < 20 && !left; k++) begin
      tick();
      if (bus.screen === 3'd0) left = 1;
    end
    nchecks++;
    if (!left) begin
      nerrors++;
      $display("FAIL blink_exit: screen %0d expected 0 within 20 cycles", bus.screen);
    end
    nchecks++;
    if (dut_digits() !== exp_digits(0, 0)) begin
      nerrors++;
      $display("FAIL blink_exit_digits: got %h expected %h", dut_digits(), exp_digits(0, 0));
    end
    bus.confirma = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    int first = -1;
    int nstep = 0;
    do_reset();
    bus.confirma = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    nchecks++;
    if (bus.screen !== 3'd0 || bus.step !== 1'b0 || dut_digits() !== exp_digits(0, 0)) begin
      nerrors++;
      $display("FAIL reset_mid_debounce: screen %0d step %b digits %h", bus.screen, bus.step, dut_digits());
    end
    tick();
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.step === 1'b1) begin
        nstep++;
        if (first < 0) first = k;
      end
    end
    nchecks++;
    if (first + 1 != LAT || nstep != 1) begin
      nerrors++;
      $display("FAIL held_through_reset: latency %0d steps %0d expected %0d and 1", first + 1, nstep, LAT);
    end
    bus.confirma = 1'b0;
    repeat (8) tick();
    press(8, 8);
    press(8, 8);
    nchecks++;
    if (bus.screen !== 3'd3) begin
      nerrors++;
      $display("FAIL reach_screen3: got %0d expected 3", bus.screen);
    end
    repeat ($urandom_range(0, 20)) tick();
    #2;
    reset = 1'b0;
    #1;
    nchecks++;
    if (bus.screen !== 3'd0 || bus.step !== 1'b0 || dut_digits() !== exp_digits(0, 0)) begin
      nerrors++;
      $display("FAIL reset_on_screen3: screen %0d step %b digits %h", bus.screen, bus.step, dut_digits());
    end
    do_reset();
    repeat (4) press(8, 8);
    repeat ($urandom_range(0, 16)) tick();
    reset = 1'b0;
    #1;
    nchecks++;
    if (bus.screen !== 3'd0 || dut_digits() !== exp_digits(0, 0)) begin
      nerrors++;
      $display("FAIL reset_on_screen4: screen %0d digits %h", bus.screen, dut_digits());
    end
  endtask

  task automatic test_random();
    int   run = 0;
    logic lvl = 1'b0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (run == 0) begin
        lvl = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 10);
      end
      bus.confirma = lvl;
      run--;
      tick();
      nchecks++;
      if (bus.step !== m_step || bus.screen !== 3'(m_scr) || dut_digits() !== exp_digits(m_scr, m_off)) begin
        nerrors++;
        $display("FAIL random_model: cycle %0d step %b/%b screen %0d/%0d digits %h/%h (got/expected)",
                 c, bus.step, m_step, bus.screen, m_scr, dut_digits(), exp_digits(m_scr, m_off));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.confirma = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_sequence();
    test_blink();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
